// File: rtl/uart_tx_mmio.sv
`default_nettype none
// ============================================================================
// uart_tx_mmio : memory-mapped 8N1 UART transmitter with TX FIFO and IRQ
// Revision     : 1.0
// ============================================================================
module uart_tx_mmio #(
  parameter logic [15:0] BASE_ADDR    = 16'h0F00,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk_m2,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [7:0]  data_i,
  input  logic        RW,
  output logic [7:0]  rd_data,
  output logic        rd_hit,
  output logic        tx,
  output logic        irq
);

  localparam int              PTR_W       = $clog2(FIFO_DEPTH);
  localparam int              CNT_W       = PTR_W + 1;
  localparam int              BCNT_W      = $clog2(CLKS_PER_BIT);
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);
  localparam logic [15:0]     STATUS_ADDR = BASE_ADDR + 16'd1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
  logic [2:0]          bit_idx_q, bit_idx_d;
  logic [7:0]          shift_q, shift_d;
  logic                tx_q, tx_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                overrun_q, overrun_d;
  logic                irq_en_q, irq_en_d;
  logic [7:0]          rd_data_q, rd_data_d;
  logic                rd_hit_q, rd_hit_d;
  logic                irq_q, irq_d;
  logic [7:0]          fifo_mem_q [FIFO_DEPTH];

  logic wr_data, wr_status, rd_status, rd_any;
  logic fifo_empty, fifo_full, tx_active, bit_end;
  logic push, pop;
  logic [7:0] status;

  always_comb begin
    wr_data    = !RW && (addr == BASE_ADDR);
    wr_status  = !RW && (addr == STATUS_ADDR);
    rd_status  = RW && (addr == STATUS_ADDR);
    rd_any     = RW && ((addr == BASE_ADDR) || (addr == STATUS_ADDR));
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == CNT_FULL);
    tx_active  = (state_q != ST_IDLE);
    bit_end    = (bcnt_q == BCNT_LAST);
    status     = {irq_en_q, 3'b000, overrun_q, tx_active, fifo_empty, fifo_full};
  end

  // Serializer: a pop loads the shifter; STOP chains straight into START when data waits.
  always_comb begin
    state_d   = state_q;
    bcnt_d    = bcnt_q + BCNT_W'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bcnt_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_mem_q[rd_ptr_q];
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          bcnt_d    = '0;
          bit_idx_d = 3'd0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          bcnt_d    = '0;
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          bcnt_d = '0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_mem_q[rd_ptr_q];
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        bcnt_d  = '0;
      end
    endcase

    // tx follows the upcoming state so the line changes on the same edge as the FSM.
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  always_comb begin
    push      = wr_data && (!fifo_full || pop);
    wr_ptr_d  = wr_ptr_q + (push ? PTR_W'(1) : PTR_W'(0));
    rd_ptr_d  = rd_ptr_q + (pop ? PTR_W'(1) : PTR_W'(0));
    count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
    overrun_d = (overrun_q && !rd_status) || (wr_data && !push);
    irq_en_d  = wr_status ? data_i[7] : irq_en_q;
    rd_data_d = rd_status ? status : 8'h00;
    rd_hit_d  = rd_any;
    irq_d     = irq_en_q && fifo_empty && !tx_active;
  end

  always_ff @(posedge clk_m2) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bcnt_q    <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      tx_q      <= 1'b1;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
      irq_en_q  <= 1'b0;
      rd_data_q <= 8'h00;
      rd_hit_q  <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bcnt_q    <= bcnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
      irq_en_q  <= irq_en_d;
      rd_data_q <= rd_data_d;
      rd_hit_q  <= rd_hit_d;
      irq_q     <= irq_d;
    end
  end

  // Storage only; validity is tracked by the pointers and count, so no reset needed.
  always_ff @(posedge clk_m2) begin
    if (!rst && push) fifo_mem_q[wr_ptr_q] <= data_i;
  end

  assign rd_data = rd_data_q;
  assign rd_hit  = rd_hit_q;
  assign tx      = tx_q;
  assign irq     = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_mmio.sv
`default_nettype none
// ============================================================================
// tb_uart_tx_mmio : randomized self-checking bench against a frame-level model
// Revision        : 1.0
// ============================================================================
module tb_uart_tx_mmio;

  localparam int          CPB     = 4;
  localparam int          FRAME   = 10 * CPB;
  localparam logic [15:0] A_DATA  = 16'h0F00;
  localparam logic [15:0] A_STAT  = 16'h0F01;

  logic        clk_m2 = 1'b0;
  logic        rst    = 1'b1;
  logic [15:0] addr   = 16'h0000;
  logic [7:0]  data_i = 8'h00;
  logic        RW     = 1'b1;
  logic [7:0]  rd_data;
  logic        rd_hit;
  logic        tx;
  logic        irq;

  int tests_run = 0;
  int tests_failed = 0;

  // Bytes expected on the line, as back-to-back frames starting at model slot k=0.
  logic [7:0] exp_q[$];

  uart_tx_mmio #(
    .BASE_ADDR   (16'h0F00),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (8)
  ) dut (
    .clk_m2 (clk_m2),
    .rst    (rst),
    .addr   (addr),
    .data_i (data_i),
    .RW     (RW),
    .rd_data(rd_data),
    .rd_hit (rd_hit),
    .tx     (tx),
    .irq    (irq)
  );

  always #5 clk_m2 = ~clk_m2;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1);
  end

  // Expected line level k cycles after the first start bit begins.
  function automatic logic exp_bit(int k);
    int f, s;
    logic [7:0] b;
    if (k < 0 || k >= FRAME * exp_q.size()) return 1'b1;
    f = k / FRAME;
    s = (k % FRAME) / CPB;
    if (s == 0) return 1'b0;
    if (s == 9) return 1'b1;
    b = exp_q[f];
    return b[s-1];
  endfunction

  task automatic tick();
    @(posedge clk_m2);
    #1;
  endtask

  task automatic bus_idle();
    RW = 1'b1; addr = 16'h0000; data_i = 8'h00;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    RW = 1'b0; addr = a; data_i = d;
  endtask

  task automatic bus_read(input logic [15:0] a);
    RW = 1'b1; addr = a; data_i = 8'h00;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_idle();
    repeat (3) tick();
    tests_run++; if (tx !== 1'b1) begin tests_failed++; $display("FAIL reset_tx actual=%b required=1", tx); end
    tests_run++; if (rd_data !== 8'h00) begin tests_failed++; $display("FAIL reset_rd_data actual=%h required=00", rd_data); end
    tests_run++; if (rd_hit !== 1'b0) begin tests_failed++; $display("FAIL reset_rd_hit actual=%b required=0", rd_hit); end
    tests_run++; if (irq !== 1'b0) begin tests_failed++; $display("FAIL reset_irq actual=%b required=0", irq); end
    rst = 1'b0;
    bus_read(A_STAT);
    tick();
    tests_run++; if (rd_data !== 8'h02) begin tests_failed++; $display("FAIL reset_status actual=%h required=02", rd_data); end
    tests_run++; if (rd_hit !== 1'b1) begin tests_failed++; $display("FAIL reset_status_hit actual=%b required=1", rd_hit); end
    bus_idle();
    tick();
  endtask

  // Writes exp_q on consecutive cycles and checks the whole serial waveform.
  task automatic test_frames(input string name);
    int n;
    logic [7:0] b[$];
    b = exp_q;
    n = b.size();
    for (int e = 0; e < FRAME * n + 8; e++) begin
      if (e < n) bus_write(A_DATA, b[e]); else bus_idle();
      tick();
      tests_run++;
      if (tx !== exp_bit(e - 1)) begin
        tests_failed++;
        $display("FAIL %s_tx slot=%0d actual=%b required=%b", name, e - 1, tx, exp_bit(e - 1));
      end
    end
    bus_idle();
  endtask

  task automatic test_overrun();
    logic [7:0] b[10];
    for (int i = 0; i < 10; i++) b[i] = 8'($urandom);
    exp_q.delete();
    for (int i = 0; i < 9; i++) exp_q.push_back(b[i]);
    for (int e = 0; e < 9 * FRAME + 20; e++) begin
      if (e < 10) bus_write(A_DATA, b[e]);
      else if (e < 12) bus_read(A_STAT);
      else bus_idle();
      tick();
      tests_run++;
      if (tx !== exp_bit(e - 1)) begin
        tests_failed++;
        $display("FAIL overrun_tx slot=%0d actual=%b required=%b", e - 1, tx, exp_bit(e - 1));
      end
      if (e == 10) begin
        tests_run++; if (rd_data !== 8'h0D) begin tests_failed++; $display("FAIL overrun_status1 actual=%h required=0D", rd_data); end
      end
      if (e == 11) begin
        tests_run++; if (rd_data !== 8'h05) begin tests_failed++; $display("FAIL overrun_status2 actual=%h required=05", rd_data); end
      end
    end
    bus_read(A_STAT);
    tick();
    tests_run++; if (rd_data !== 8'h02) begin tests_failed++; $display("FAIL overrun_drained actual=%h required=02", rd_data); end
    bus_idle();
  endtask

  // FIFO full: a write on the edge the shifter pops is kept, one edge earlier it is dropped.
  task automatic test_full_pop();
    logic [7:0] b[9];
    logic [7:0] x, y;
    for (int i = 0; i < 9; i++) b[i] = 8'($urandom);
    x = 8'($urandom);
    y = 8'($urandom);
    exp_q.delete();
    for (int i = 0; i < 9; i++) exp_q.push_back(b[i]);
    exp_q.push_back(y);
    for (int e = 0; e < 10 * FRAME + 10; e++) begin
      if (e < 9) bus_write(A_DATA, b[e]);
      else if (e == FRAME) bus_write(A_DATA, x);
      else if (e == FRAME + 1) bus_write(A_DATA, y);
      else bus_idle();
      tick();
      tests_run++;
      if (tx !== exp_bit(e - 1)) begin
        tests_failed++;
        $display("FAIL full_pop_tx slot=%0d actual=%b required=%b", e - 1, tx, exp_bit(e - 1));
      end
    end
    bus_read(A_STAT);
    tick();
    tests_run++; if (rd_data !== 8'h0A) begin tests_failed++; $display("FAIL full_pop_status actual=%h required=0A", rd_data); end
    tick();
    tests_run++; if (rd_data !== 8'h02) begin tests_failed++; $display("FAIL full_pop_cleared actual=%h required=02", rd_data); end
    bus_idle();
  endtask

  task automatic test_irq();
    logic [7:0] b;
    b = 8'($urandom);
    exp_q.delete();
    exp_q.push_back(b);
    bus_write(A_STAT, 8'h80);
    tick();
    bus_idle();
    tick();
    tests_run++; if (irq !== 1'b1) begin tests_failed++; $display("FAIL irq_enable actual=%b required=1", irq); end
    bus_read(A_STAT);
    tick();
    tests_run++; if (rd_data !== 8'h82) begin tests_failed++; $display("FAIL irq_status actual=%h required=82", rd_data); end
    bus_write(A_DATA, b);
    tick();
    for (int j = 1; j <= FRAME + 4; j++) begin
      bus_idle();
      tick();
      tests_run++;
      if (irq !== (j >= FRAME + 2)) begin
        tests_failed++;
        $display("FAIL irq_level j=%0d actual=%b required=%b", j, irq, (j >= FRAME + 2));
      end
      tests_run++;
      if (tx !== exp_bit(j - 1)) begin
        tests_failed++;
        $display("FAIL irq_tx slot=%0d actual=%b required=%b", j - 1, tx, exp_bit(j - 1));
      end
    end
    bus_write(A_STAT, 8'h7F);
    tick();
    bus_idle();
    tick();
    tests_run++; if (irq !== 1'b0) begin tests_failed++; $display("FAIL irq_disable actual=%b required=0", irq); end
  endtask

  task automatic test_reset_mid();
    for (int e = 0; e < 20; e++) begin
      if (e < 4) bus_write(A_DATA, 8'($urandom)); else bus_idle();
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests_run++; if (tx !== 1'b1) begin tests_failed++; $display("FAIL reset_mid_tx actual=%b required=1", tx); end
    tests_run++; if (irq !== 1'b0) begin tests_failed++; $display("FAIL reset_mid_irq actual=%b required=0", irq); end
    for (int e = 0; e < 4 * FRAME; e++) begin
      tick();
      tests_run++;
      if (tx !== 1'b1) begin
        tests_failed++;
        $display("FAIL reset_mid_idle cycle=%0d actual=%b required=1", e, tx);
      end
    end
    bus_read(A_STAT);
    tick();
    tests_run++; if (rd_data !== 8'h02) begin tests_failed++; $display("FAIL reset_mid_status actual=%h required=02", rd_data); end
    bus_idle();
  endtask

  task automatic test_bad_addr();
    bus_write(16'h0F02, 8'h5A);
    tick();
    bus_read(16'h0100);
    tick();
    tests_run++; if (rd_hit !== 1'b0) begin tests_failed++; $display("FAIL bad_addr_hit actual=%b required=0", rd_hit); end
    tests_run++; if (rd_data !== 8'h00) begin tests_failed++; $display("FAIL bad_addr_data actual=%h required=00", rd_data); end
    bus_idle();
    for (int e = 0; e < 20; e++) begin
      tick();
      tests_run++;
      if (tx !== 1'b1) begin tests_failed++; $display("FAIL bad_addr_tx cycle=%0d actual=%b required=1", e, tx); end
    end
    bus_read(A_STAT);
    tick();
    tests_run++; if (rd_data !== 8'h02) begin tests_failed++; $display("FAIL bad_addr_status actual=%h required=02", rd_data); end
    bus_read(A_DATA);
    tick();
    tests_run++; if (rd_hit !== 1'b1) begin tests_failed++; $display("FAIL data_read_hit actual=%b required=1", rd_hit); end
    tests_run++; if (rd_data !== 8'h00) begin tests_failed++; $display("FAIL data_read_data actual=%h required=00", rd_data); end
    bus_idle();
    tick();
    tests_run++; if (rd_hit !== 1'b0) begin tests_failed++; $display("FAIL idle_hit actual=%b required=0", rd_hit); end
  endtask

  initial begin
    int n;
    test_reset();

    exp_q.delete();
    exp_q.push_back(8'h41);
    test_frames("single");

    test_overrun();

    exp_q.delete();
    exp_q.push_back(8'h55);
    exp_q.push_back(8'hAA);
    test_frames("back_to_back");

    test_full_pop();

    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(1, 8);
      exp_q.delete();
      for (int i = 0; i < n; i++) exp_q.push_back(8'($urandom));
      test_frames("random");
    end

    test_irq();
    test_reset_mid();
    test_bad_addr();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
